descriptor_memory_arbiter: RTL and testbench
============================================

DESCRIPTOR_MEMORY_ARBITER -- requirements
Module: descriptor_memory_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 11, word address width of the descriptor RAM.
REQ-002 SHALL have parameter DATA_W, default 32, data width; byteenable width = DATA_W/8.
REQ-003 SHALL have parameter MAX_LOCK, default 16, max consecutive locked grant cycles per owner, range 1..255.
REQ-004 SHALL have port clk  in  1  sole clock, all state rising-edge.
REQ-005 SHALL have port reset_n  in  1  asynchronous, active-low reset.
REQ-006 SHALL have, for X in {0,1}: mX_address in ADDR_W; mX_byteenable in DATA_W/8; mX_read in 1; mX_write in 1; mX_writedata in DATA_W; mX_lock in 1 (hold grant for read-modify-write).
REQ-007 SHALL have, for X in {0,1}: mX_waitrequest out 1; mX_readdata out DATA_W; mX_readdatavalid out 1.
REQ-008 SHALL have RAM-side ports: mem_address out ADDR_W; mem_byteenable out DATA_W/8; mem_chipselect out 1; mem_write out 1; mem_writedata out DATA_W; mem_clken out 1; mem_readdata in DATA_W.

Function
REQ-009 SHALL treat master X as requesting when mX_read|mX_write; both asserted together is illegal, write takes precedence.
REQ-010 SHALL implement FSM IDLE, OWN0, OWN1; reset state IDLE.
REQ-011 SHALL, when no lock is held, grant in the same cycle (combinationally) using round-robin: sole requester wins; if both request, winner = master not granted last (last_grant reset 1, so m0 wins first contention).
REQ-012 SHALL drive mem_* combinationally from the winner: mem_chipselect=1, mem_write=winner write, address/byteenable/writedata from winner; with no winner mem_chipselect=0, mem_write=0, other mem_* = 0.
REQ-013 SHALL tie mem_clken to 1.
REQ-014 SHALL assert mX_waitrequest exactly when master X requests and is not the winner; never when not requesting.
REQ-015 SHALL accept one transfer per cycle; back-to-back transfers from the same master at full rate when uncontended.
REQ-016 SHALL, for an accepted read, assert mX_readdatavalid for exactly one cycle, 1 cycle after acceptance, to the issuing master only; mX_readdata = mem_readdata for both masters (qualified by readdatavalid).
REQ-017 SHALL enter OWNX from IDLE/other state when X wins an accepted transfer with mX_lock=1; otherwise go/stay IDLE.
REQ-018 SHALL, in OWNX, grant only X while mX_lock=1; the other master is waitrequested even if X is idle that cycle.
REQ-019 SHALL count locked cycles in OWNX (8-bit counter, cleared on entry); when count reaches MAX_LOCK and the other master requests, force next grant to the other master and return to IDLE regardless of mX_lock.
REQ-020 SHALL leave OWNX to IDLE the cycle after mX_lock deasserts; that cycle arbitrates per REQ-011.
REQ-021 SHALL update last_grant on every accepted transfer.
REQ-022 SHALL keep mem_address/writedata stable only as driven by the winning master; no internal buffering of write data.

Reset
REQ-023 SHALL, while reset_n=0, force FSM=IDLE, last_grant=1, lock counter=0, readdatavalid pipe=0.
REQ-024 SHALL, after reset, output mX_waitrequest=0 (no requests), mX_readdatavalid=0, mem_chipselect=0, mem_write=0, mem_clken=1.
REQ-025 SHALL discard an in-flight read on reset; no readdatavalid after reset deassertion for pre-reset reads.

Structure
REQ-026 SHALL place state encoding (IDLE/OWN0/OWN1) and MAX_LOCK default in shared package descriptor_memory_pkg.
REQ-027 SHALL contain one sub-module, descriptor_memory_rr_pick (2-request round-robin picker with last_grant input); RAM instance stays outside.

Verification
REQ-028 SHALL cover: m0 read addr 0x010 alone -> mem_chipselect=1, no waitrequest, m0_readdatavalid at +1 cycle with RAM word, m1_readdatavalid=0.
REQ-029 SHALL cover: m0 and m1 write same cycle after reset -> m0 granted, m1 waitrequest 1 cycle, m1 granted next; next contention -> m1 first... alternates.
REQ-030 SHALL cover: m1 lock read 0x7FF then write 0x7FF with m0 requesting -> m0 waitrequested until cycle after m1_lock drops; RAM holds m1 value.
REQ-031 SHALL cover: m0 holds lock 40 cycles, MAX_LOCK=16, m1 requesting -> m1 granted at locked-cycle 16, FSM IDLE.
REQ-032 SHALL cover: reset_n pulsed low the cycle after a read acceptance -> no readdatavalid afterwards, all outputs at REQ-024 values.
REQ-033 SHALL cover: byteenable 4'b0010 write from m1 -> mem_byteenable=4'b0010, only byte 1 changes on readback.

Source files
------------

// File: rtl/descriptor_memory_pkg.sv
// Shared definitions for the descriptor RAM arbiter: FSM encoding and lock quota default.
package descriptor_memory_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN0 = 2'd1,
    OWN1 = 2'd2
  } arb_state_t;

  localparam int MAX_LOCK_DEFAULT = 16;
  localparam int LOCK_CNT_W       = 8;

endpackage

// File: rtl/descriptor_memory_rr_pick.sv
// Two-request round-robin picker: on contention the master not granted last wins.
module descriptor_memory_rr_pick
  import descriptor_memory_pkg::*;
(
  input  logic req0,
  input  logic req1,
  input  logic last_grant,
  output logic grant0,
  output logic grant1
);

  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
    if (req0 && req1) begin
      grant0 = last_grant;
      grant1 = !last_grant;
    end else begin
      grant0 = req0;
      grant1 = req1;
    end
  end

endmodule

// File: rtl/descriptor_memory_arbiter.sv
// Two-master arbiter in front of a single-port descriptor RAM, with lock support
// for read-modify-write and a bounded lock quota per owner.
module descriptor_memory_arbiter
  import descriptor_memory_pkg::*;
#(
  parameter int ADDR_W   = 11,
  parameter int DATA_W   = 32,
  parameter int MAX_LOCK = MAX_LOCK_DEFAULT
) (
  input  logic                clk,
  input  logic                reset_n,

  input  logic [ADDR_W-1:0]   m0_address,
  input  logic [DATA_W/8-1:0] m0_byteenable,
  input  logic                m0_read,
  input  logic                m0_write,
  input  logic [DATA_W-1:0]   m0_writedata,
  input  logic                m0_lock,
  output logic                m0_waitrequest,
  output logic [DATA_W-1:0]   m0_readdata,
  output logic                m0_readdatavalid,

  input  logic [ADDR_W-1:0]   m1_address,
  input  logic [DATA_W/8-1:0] m1_byteenable,
  input  logic                m1_read,
  input  logic                m1_write,
  input  logic [DATA_W-1:0]   m1_writedata,
  input  logic                m1_lock,
  output logic                m1_waitrequest,
  output logic [DATA_W-1:0]   m1_readdata,
  output logic                m1_readdatavalid,

  output logic [ADDR_W-1:0]   mem_address,
  output logic [DATA_W/8-1:0] mem_byteenable,
  output logic                mem_chipselect,
  output logic                mem_write,
  output logic [DATA_W-1:0]   mem_writedata,
  output logic                mem_clken,
  input  logic [DATA_W-1:0]   mem_readdata
);

  localparam logic [LOCK_CNT_W-1:0] MAX_LOCK_C = LOCK_CNT_W'(MAX_LOCK);

  arb_state_t              state;
  logic                    last_grant;
  logic [LOCK_CNT_W-1:0]   lock_cnt;
  logic                    rvalid0_p1;
  logic                    rvalid1_p1;

  logic req0;
  logic req1;
  logic rr_grant0;
  logic rr_grant1;
  logic grant0;
  logic grant1;
  logic quota_exit;
  logic lock_hold;

  assign req0 = m0_read | m0_write;
  assign req1 = m1_read | m1_write;

  descriptor_memory_rr_pick u_rr_pick (
    .req0       (req0),
    .req1       (req1),
    .last_grant (last_grant),
    .grant0     (rr_grant0),
    .grant1     (rr_grant1)
  );

  // A locked owner keeps exclusive access until its quota runs out while the other master waits.
  always_comb begin
    grant0     = rr_grant0;
    grant1     = rr_grant1;
    quota_exit = 1'b0;
    lock_hold  = 1'b0;
    case (state)
      OWN0: begin
        if (m0_lock) begin
          if (lock_cnt >= MAX_LOCK_C && req1) begin
            grant0     = 1'b0;
            grant1     = 1'b1;
            quota_exit = 1'b1;
          end else begin
            grant0    = req0;
            grant1    = 1'b0;
            lock_hold = 1'b1;
          end
        end
      end
      OWN1: begin
        if (m1_lock) begin
          if (lock_cnt >= MAX_LOCK_C && req0) begin
            grant0     = 1'b1;
            grant1     = 1'b0;
            quota_exit = 1'b1;
          end else begin
            grant0    = 1'b0;
            grant1    = req1;
            lock_hold = 1'b1;
          end
        end
      end
      default: ;
    endcase
  end

  always_comb begin
    mem_chipselect = grant0 | grant1;
    mem_write      = 1'b0;
    mem_address    = '0;
    mem_byteenable = '0;
    mem_writedata  = '0;
    if (grant0) begin
      mem_write      = m0_write;
      mem_address    = m0_address;
      mem_byteenable = m0_byteenable;
      mem_writedata  = m0_writedata;
    end else if (grant1) begin
      mem_write      = m1_write;
      mem_address    = m1_address;
      mem_byteenable = m1_byteenable;
      mem_writedata  = m1_writedata;
    end
  end

  assign mem_clken        = 1'b1;
  assign m0_waitrequest   = req0 & ~grant0;
  assign m1_waitrequest   = req1 & ~grant1;
  assign m0_readdata      = mem_readdata;
  assign m1_readdata      = mem_readdata;
  assign m0_readdatavalid = rvalid0_p1;
  assign m1_readdatavalid = rvalid1_p1;

  // p0 -> p1: read acceptance becomes readdatavalid alongside the RAM's registered output.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      last_grant <= 1'b1;
      lock_cnt   <= '0;
      rvalid0_p1 <= 1'b0;
      rvalid1_p1 <= 1'b0;
    end else begin
      rvalid0_p1 <= grant0 & ~m0_write;
      rvalid1_p1 <= grant1 & ~m1_write;
      if (grant0 || grant1) begin
        last_grant <= grant1;
      end
      if (lock_hold && !quota_exit) begin
        if (lock_cnt != '1) begin
          lock_cnt <= lock_cnt + 1'b1;
        end
      end else if (grant0 && m0_lock) begin
        state    <= OWN0;
        lock_cnt <= '0;
      end else if (grant1 && m1_lock) begin
        state    <= OWN1;
        lock_cnt <= '0;
      end else begin
        state    <= IDLE;
        lock_cnt <= '0;
      end
    end
  end

endmodule

// File: tb/tb_descriptor_memory_arbiter.sv
// Directed bench for descriptor_memory_arbiter: vector table plus lock-quota and reset sequences.
module tb_descriptor_memory_arbiter;
  import descriptor_memory_pkg::*;

  localparam logic O = 1'b0;
  localparam logic I = 1'b1;
  localparam int   NV = 22;

  typedef struct packed {
    logic        r0, w0, l0;
    logic [10:0] a0;
    logic [3:0]  be0;
    logic [31:0] d0;
    logic        r1, w1, l1;
    logic [10:0] a1;
    logic [3:0]  be1;
    logic [31:0] d1;
    logic        wt0, wt1, rv0, rv1, cs, we;
    logic [10:0] ma;
    logic [3:0]  mbe;
    logic        crd;
    logic [31:0] rd;
  } vec_t;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [10:0] m0_address, m1_address;
  logic [3:0]  m0_byteenable, m1_byteenable;
  logic        m0_read, m0_write, m0_lock, m1_read, m1_write, m1_lock;
  logic [31:0] m0_writedata, m1_writedata;
  logic        m0_waitrequest, m1_waitrequest, m0_readdatavalid, m1_readdatavalid;
  logic [31:0] m0_readdata, m1_readdata;
  logic [10:0] mem_address;
  logic [3:0]  mem_byteenable;
  logic        mem_chipselect, mem_write, mem_clken;
  logic [31:0] mem_writedata;
  logic [31:0] mem_readdata;

  int checks = 0;
  int errors = 0;

  vec_t tbl [NV];

  descriptor_memory_arbiter dut (
    .clk(clk), .reset_n(reset_n),
    .m0_address(m0_address), .m0_byteenable(m0_byteenable), .m0_read(m0_read),
    .m0_write(m0_write), .m0_writedata(m0_writedata), .m0_lock(m0_lock),
    .m0_waitrequest(m0_waitrequest), .m0_readdata(m0_readdata), .m0_readdatavalid(m0_readdatavalid),
    .m1_address(m1_address), .m1_byteenable(m1_byteenable), .m1_read(m1_read),
    .m1_write(m1_write), .m1_writedata(m1_writedata), .m1_lock(m1_lock),
    .m1_waitrequest(m1_waitrequest), .m1_readdata(m1_readdata), .m1_readdatavalid(m1_readdatavalid),
    .mem_address(mem_address), .mem_byteenable(mem_byteenable), .mem_chipselect(mem_chipselect),
    .mem_write(mem_write), .mem_writedata(mem_writedata), .mem_clken(mem_clken),
    .mem_readdata(mem_readdata)
  );

  always #5 clk = ~clk;

  // Single-port RAM with one-cycle registered read; word a starts as C0DE0000 + a.
  logic [31:0] ram [0:2047];
  logic        ram_ready = 1'b0;
  always @(posedge clk) begin
    if (!ram_ready) begin
      for (int i = 0; i < 2048; i++) ram[i] = 32'hC0DE_0000 + 32'(i);
      ram_ready <= 1'b1;
    end else if (mem_chipselect && mem_clken) begin
      if (mem_write) begin
        for (int b = 0; b < 4; b++)
          if (mem_byteenable[b]) ram[mem_address][8*b +: 8] <= mem_writedata[8*b +: 8];
      end else begin
        mem_readdata <= ram[mem_address];
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    m0_read = v.r0; m0_write = v.w0; m0_lock = v.l0; m0_address = v.a0;
    m0_byteenable = v.be0; m0_writedata = v.d0;
    m1_read = v.r1; m1_write = v.w1; m1_lock = v.l1; m1_address = v.a1;
    m1_byteenable = v.be1; m1_writedata = v.d1;
  endtask

  task automatic idle_inputs();
    vec_t z;
    z = '0;
    drive(z);
  endtask

  task automatic chk_quiet(input string tag);
    chk({tag, " wt0"}, 32'(m0_waitrequest), 32'(0));
    chk({tag, " wt1"}, 32'(m1_waitrequest), 32'(0));
    chk({tag, " rv0"}, 32'(m0_readdatavalid), 32'(0));
    chk({tag, " rv1"}, 32'(m1_readdatavalid), 32'(0));
    chk({tag, " cs"}, 32'(mem_chipselect), 32'(0));
    chk({tag, " we"}, 32'(mem_write), 32'(0));
    chk({tag, " clken"}, 32'(mem_clken), 32'(1));
  endtask

  initial begin
    bit m1_done;
    // inputs-then-expected, one row per clock cycle
    tbl[0]  = '{O,O,O,11'h000,4'h0,32'h0, O,O,O,11'h000,4'h0,32'h0, O,O,O,O,O,O,11'h000,4'h0,O,32'h0};
    tbl[1]  = '{O,I,O,11'h020,4'hF,32'h11111111, O,I,O,11'h021,4'hF,32'h22222222, O,I,O,O,I,I,11'h020,4'hF,O,32'h0};
    tbl[2]  = '{O,I,O,11'h022,4'hF,32'h33333333, O,I,O,11'h021,4'hF,32'h22222222, I,O,O,O,I,I,11'h021,4'hF,O,32'h0};
    tbl[3]  = '{O,I,O,11'h022,4'hF,32'h33333333, O,I,O,11'h023,4'hF,32'h44444444, O,I,O,O,I,I,11'h022,4'hF,O,32'h0};
    tbl[4]  = '{O,O,O,11'h000,4'h0,32'h0, O,I,O,11'h023,4'hF,32'h44444444, O,O,O,O,I,I,11'h023,4'hF,O,32'h0};
    tbl[5]  = '{I,O,O,11'h010,4'hF,32'h0, O,O,O,11'h000,4'h0,32'h0, O,O,O,O,I,O,11'h010,4'hF,O,32'h0};
    tbl[6]  = '{O,O,O,11'h000,4'h0,32'h0, O,O,O,11'h000,4'h0,32'h0, O,O,I,O,O,O,11'h000,4'h0,I,32'hC0DE0010};
    tbl[7]  = '{I,O,O,11'h020,4'hF,32'h0, O,O,O,11'h000,4'h0,32'h0, O,O,O,O,I,O,11'h020,4'hF,O,32'h0};
    tbl[8]  = '{O,O,O,11'h000,4'h0,32'h0, I,O,O,11'h021,4'hF,32'h0, O,O,I,O,I,O,11'h021,4'hF,I,32'h11111111};
    tbl[9]  = '{I,O,O,11'h022,4'hF,32'h0, I,O,O,11'h023,4'hF,32'h0, O,I,O,I,I,O,11'h022,4'hF,I,32'h22222222};
    tbl[10] = '{O,O,O,11'h000,4'h0,32'h0, I,O,O,11'h023,4'hF,32'h0, O,O,I,O,I,O,11'h023,4'hF,I,32'h33333333};
    tbl[11] = '{I,I,O,11'h030,4'hF,32'h55555555, O,O,O,11'h000,4'h0,32'h0, O,O,O,I,I,I,11'h030,4'hF,I,32'h44444444};
    tbl[12] = '{I,O,O,11'h030,4'hF,32'h0, O,O,O,11'h000,4'h0,32'h0, O,O,O,O,I,O,11'h030,4'hF,O,32'h0};
    tbl[13] = '{O,O,O,11'h000,4'h0,32'h0, O,I,O,11'h040,4'h2,32'hAABBCCDD, O,O,I,O,I,I,11'h040,4'h2,I,32'h55555555};
    tbl[14] = '{O,O,O,11'h000,4'h0,32'h0, I,O,O,11'h040,4'hF,32'h0, O,O,O,O,I,O,11'h040,4'hF,O,32'h0};
    tbl[15] = '{O,O,O,11'h000,4'h0,32'h0, O,O,O,11'h000,4'h0,32'h0, O,O,O,I,O,O,11'h000,4'h0,I,32'hC0DECC40};
    tbl[16] = '{O,O,O,11'h000,4'h0,32'h0, I,O,I,11'h7FF,4'hF,32'h0, O,O,O,O,I,O,11'h7FF,4'hF,O,32'h0};
    tbl[17] = '{I,O,O,11'h010,4'hF,32'h0, O,O,I,11'h7FF,4'hF,32'h0, I,O,O,I,O,O,11'h000,4'h0,I,32'hC0DE07FF};
    tbl[18] = '{I,O,O,11'h010,4'hF,32'h0, O,I,I,11'h7FF,4'hF,32'h7FF00001, I,O,O,O,I,I,11'h7FF,4'hF,O,32'h0};
    tbl[19] = '{I,O,O,11'h010,4'hF,32'h0, O,O,O,11'h7FF,4'hF,32'h0, O,O,O,O,I,O,11'h010,4'hF,O,32'h0};
    tbl[20] = '{I,O,O,11'h7FF,4'hF,32'h0, O,O,O,11'h000,4'h0,32'h0, O,O,I,O,I,O,11'h7FF,4'hF,I,32'hC0DE0010};
    tbl[21] = '{O,O,O,11'h000,4'h0,32'h0, O,O,O,11'h000,4'h0,32'h0, O,O,I,O,O,O,11'h000,4'h0,I,32'h7FF00001};

    reset_n = 1'b0;
    idle_inputs();
    repeat (3) @(posedge clk);
    #1 reset_n = 1'b1;

    for (int i = 0; i < NV; i++) begin
      string t;
      t = $sformatf("row%0d", i);
      drive(tbl[i]);
      @(negedge clk);
      chk({t, " wt0"}, 32'(m0_waitrequest), 32'(tbl[i].wt0));
      chk({t, " wt1"}, 32'(m1_waitrequest), 32'(tbl[i].wt1));
      chk({t, " rv0"}, 32'(m0_readdatavalid), 32'(tbl[i].rv0));
      chk({t, " rv1"}, 32'(m1_readdatavalid), 32'(tbl[i].rv1));
      chk({t, " cs"}, 32'(mem_chipselect), 32'(tbl[i].cs));
      chk({t, " we"}, 32'(mem_write), 32'(tbl[i].we));
      chk({t, " addr"}, 32'(mem_address), 32'(tbl[i].ma));
      chk({t, " be"}, 32'(mem_byteenable), 32'(tbl[i].mbe));
      chk({t, " clken"}, 32'(mem_clken), 32'(1));
      if (tbl[i].crd) begin
        if (tbl[i].rv0) chk({t, " rd0"}, m0_readdata, tbl[i].rd);
        else            chk({t, " rd1"}, m1_readdata, tbl[i].rd);
      end
      @(posedge clk);
      #1;
    end

    // Lock quota: m0 holds a lock, m1 waits and is forced in after MAX_LOCK locked cycles.
    m0_read = 1'b1; m0_lock = 1'b1; m0_address = 11'h100; m0_byteenable = 4'hF;
    @(negedge clk);
    chk("quota entry cs", 32'(mem_chipselect), 32'(1));
    chk("quota entry addr", 32'(mem_address), 32'h100);
    @(posedge clk);
    #1;
    m1_done = 1'b0;
    for (int k = 0; k < 39; k++) begin
      m1_read = !m1_done; m1_address = 11'h101; m1_byteenable = 4'hF;
      @(negedge clk);
      if (k < 16) begin
        chk($sformatf("quota k%0d wt1", k), 32'(m1_waitrequest), 32'(1));
        chk($sformatf("quota k%0d addr", k), 32'(mem_address), 32'h100);
      end else if (k == 16) begin
        chk("quota force wt0", 32'(m0_waitrequest), 32'(1));
        chk("quota force wt1", 32'(m1_waitrequest), 32'(0));
        chk("quota force addr", 32'(mem_address), 32'h101);
      end else if (k == 17) begin
        chk("quota state idle", 32'(dut.state), 32'(IDLE));
        chk("quota m1 rv", 32'(m1_readdatavalid), 32'(1));
        chk("quota m1 rd", m1_readdata, 32'hC0DE0101);
        chk("quota m0 regrant", 32'(m0_waitrequest), 32'(0));
      end
      if (k == 16) m1_done = 1'b1;
      @(posedge clk);
      #1;
    end
    idle_inputs();
    @(posedge clk);
    #1;

    // Reset pulse right after a read is accepted discards the pending readdatavalid.
    m0_read = 1'b1; m0_address = 11'h010; m0_byteenable = 4'hF;
    @(negedge clk);
    chk("rst accept cs", 32'(mem_chipselect), 32'(1));
    @(posedge clk);
    #1;
    idle_inputs();
    reset_n = 1'b0;
    @(negedge clk);
    chk("rst during rv0", 32'(m0_readdatavalid), 32'(0));
    @(posedge clk);
    #1 reset_n = 1'b1;
    @(negedge clk);
    chk_quiet("post rst");
    @(posedge clk);
    #1;
    m0_read = 1'b1; m0_address = 11'h010; m0_byteenable = 4'hF;
    m1_read = 1'b1; m1_address = 11'h020; m1_byteenable = 4'hF;
    @(negedge clk);
    chk("post rst m0 first wt1", 32'(m1_waitrequest), 32'(1));
    chk("post rst m0 first addr", 32'(mem_address), 32'h010);
    @(posedge clk);
    #1 idle_inputs();
    @(negedge clk);
    chk("post rst rv0", 32'(m0_readdatavalid), 32'(1));
    chk("post rst rd0", m0_readdata, 32'hC0DE0010);
    @(posedge clk);
    #1;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
